// File: rtl/y86_pkg.sv
// Shared Y86-64 constants and the D->E pipeline register payload.
package y86_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned NREG   = 15;
  localparam int unsigned ID_W   = 4;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [ID_W-1:0] RNONE = 4'hF;
  localparam logic [ID_W-1:0] RRSP  = 4'h4;

  typedef struct packed {
    logic              valid;
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [DATA_W-1:0] val_c;
    logic [DATA_W-1:0] val_a;
    logic [DATA_W-1:0] val_b;
    logic [ID_W-1:0]   src_a;
    logic [ID_W-1:0]   src_b;
    logic [ID_W-1:0]   dst_e;
    logic [ID_W-1:0]   dst_m;
    logic              ins_err;
  } de_t;

  localparam de_t DE_BUBBLE = '{
    valid: 1'b0, icode: INOP, ifun: 4'h0,
    val_c: '0, val_a: '0, val_b: '0,
    src_a: RNONE, src_b: RNONE, dst_e: RNONE, dst_m: RNONE,
    ins_err: 1'b0
  };

endpackage

// File: rtl/y86_regfile.sv
// 15 x DATA_W register file: 2 combinational reads, 2 synchronous writes (M wins).
// Optional same-cycle write->read forwarding under DECODE_WB_BYPASS_EN.
module y86_regfile
  import y86_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   rd_a_id,
  input  logic [ID_W-1:0]   rd_b_id,
  output logic [DATA_W-1:0] rd_a_val_c,
  output logic [DATA_W-1:0] rd_b_val_c,
  input  logic [ID_W-1:0]   we_dst,
  input  logic [DATA_W-1:0] we_val,
  input  logic [ID_W-1:0]   wm_dst,
  input  logic [DATA_W-1:0] wm_val
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  function automatic logic [DATA_W-1:0] rd_port(input logic [ID_W-1:0] id);
    logic [DATA_W-1:0] v;
    v = '0;
    if (id != RNONE) v = regs_q[id];
`ifdef DECODE_WB_BYPASS_EN
    if (id != RNONE && id == we_dst) v = we_val;
    if (id != RNONE && id == wm_dst) v = wm_val;
`endif
    return v;
  endfunction

  always_comb begin
    rd_a_val_c = rd_port(rd_a_id);
    rd_b_val_c = rd_port(rd_b_id);
  end

  // M port applied last so it overrides E on a shared destination.
  always_comb begin
    regs_d = regs_q;
    if (we_dst != RNONE) regs_d[we_dst] = we_val;
    if (wm_dst != RNONE) regs_d[wm_dst] = wm_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: rtl/y86_decode_stage.sv
// Y86-64 decode/write-back stage feeding the D->E pipeline register.
// Build option: DECODE_WB_BYPASS_EN forwards same-cycle write-back data to reads.
module y86_decode_stage
  import y86_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [DATA_W-1:0] valC,
  input  logic [DATA_W-1:0] valP,
  input  logic              stall,
  input  logic              bubble,
  input  logic [3:0]        wE_dst,
  input  logic [DATA_W-1:0] wE_val,
  input  logic [3:0]        wM_dst,
  input  logic [DATA_W-1:0] wM_val,
  output logic              e_valid,
  output logic [3:0]        e_icode,
  output logic [3:0]        e_ifun,
  output logic [DATA_W-1:0] e_valC,
  output logic [DATA_W-1:0] e_valA,
  output logic [DATA_W-1:0] e_valB,
  output logic [3:0]        e_srcA,
  output logic [3:0]        e_srcB,
  output logic [3:0]        e_dstE,
  output logic [3:0]        e_dstM,
  output logic              e_ins_err
);

  logic              ins_err_c;
  logic [ID_W-1:0]   src_a_c, src_b_c, dst_e_c, dst_m_c;
  logic [DATA_W-1:0] rd_a_c, rd_b_c, val_a_c;
  de_t               de_q, de_d;

  // Register ID selection; an illegal icode touches no registers.
  always_comb begin
    ins_err_c = (icode > 4'hB);
    src_a_c = RNONE;
    src_b_c = RNONE;
    dst_e_c = RNONE;
    dst_m_c = RNONE;
    case (icode)
      IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: src_a_c = rA;
      IRET, IPOPQ:                    src_a_c = RRSP;
      default: ;
    endcase
    case (icode)
      IRMMOVQ, IMRMOVQ, IOPQ:         src_b_c = rB;
      ICALL, IRET, IPUSHQ, IPOPQ:     src_b_c = RRSP;
      default: ;
    endcase
    case (icode)
      IRRMOVQ, IIRMOVQ, IOPQ:         dst_e_c = rB;
      ICALL, IRET, IPUSHQ, IPOPQ:     dst_e_c = RRSP;
      default: ;
    endcase
    case (icode)
      IMRMOVQ, IPOPQ:                 dst_m_c = rA;
      default: ;
    endcase
  end

  y86_regfile u_regfile (
    .clk        (clk),
    .rst        (rst),
    .rd_a_id    (src_a_c),
    .rd_b_id    (src_b_c),
    .rd_a_val_c (rd_a_c),
    .rd_b_val_c (rd_b_c),
    .we_dst     (wE_dst),
    .we_val     (wE_val),
    .wm_dst     (wM_dst),
    .wm_val     (wM_val)
  );

  always_comb begin
    val_a_c = (icode == IJXX || icode == ICALL) ? valP : rd_a_c;
  end

  // D->E register next state: bubble beats stall, idle cycles insert bubbles.
  always_comb begin
    de_d = DE_BUBBLE;
    if (bubble) begin
      de_d = DE_BUBBLE;
    end else if (stall) begin
      de_d = de_q;
    end else if (in_valid) begin
      de_d.valid   = 1'b1;
      de_d.icode   = icode;
      de_d.ifun    = ifun;
      de_d.val_c   = valC;
      de_d.val_a   = val_a_c;
      de_d.val_b   = rd_b_c;
      de_d.src_a   = src_a_c;
      de_d.src_b   = src_b_c;
      de_d.dst_e   = dst_e_c;
      de_d.dst_m   = dst_m_c;
      de_d.ins_err = ins_err_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) de_q <= DE_BUBBLE;
    else     de_q <= de_d;
  end

  always_comb begin
    e_valid   = de_q.valid;
    e_icode   = de_q.icode;
    e_ifun    = de_q.ifun;
    e_valC    = de_q.val_c;
    e_valA    = de_q.val_a;
    e_valB    = de_q.val_b;
    e_srcA    = de_q.src_a;
    e_srcB    = de_q.src_b;
    e_dstE    = de_q.dst_e;
    e_dstM    = de_q.dst_m;
    e_ins_err = de_q.ins_err;
  end

endmodule

// File: tb/tb_y86_decode_stage.sv
// Directed self-checking bench for y86_decode_stage (either DECODE_WB_BYPASS_EN build).
module tb_y86_decode_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, stall, bubble;
  logic [3:0]  icode, ifun, rA, rB, wE_dst, wM_dst;
  logic [63:0] valC, valP, wE_val, wM_val;
  logic        e_valid, e_ins_err;
  logic [3:0]  e_icode, e_ifun, e_srcA, e_srcB, e_dstE, e_dstM;
  logic [63:0] e_valC, e_valA, e_valB;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  y86_decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .icode(icode), .ifun(ifun),
    .rA(rA), .rB(rB), .valC(valC), .valP(valP), .stall(stall), .bubble(bubble),
    .wE_dst(wE_dst), .wE_val(wE_val), .wM_dst(wM_dst), .wM_val(wM_val),
    .e_valid(e_valid), .e_icode(e_icode), .e_ifun(e_ifun), .e_valC(e_valC),
    .e_valA(e_valA), .e_valB(e_valB), .e_srcA(e_srcA), .e_srcB(e_srcB),
    .e_dstE(e_dstE), .e_dstM(e_dstM), .e_ins_err(e_ins_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; stall = 1'b0; bubble = 1'b0;
    icode = 4'h1; ifun = 4'h0; rA = 4'hF; rB = 4'hF;
    valC = '0; valP = '0;
    wE_dst = 4'hF; wE_val = '0; wM_dst = 4'hF; wM_val = '0;
  endtask

  task automatic feed(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                      input logic [63:0] vc, input logic [63:0] vp);
    in_valid = 1'b1; icode = ic; ifun = 4'h0; rA = ra; rB = rb; valC = vc; valP = vp;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, ".valid"}, 64'(e_valid), 64'h0);
    check({tag, ".icode"}, 64'(e_icode), 64'h1);
    check({tag, ".srcA"},  64'(e_srcA),  64'hF);
    check({tag, ".srcB"},  64'(e_srcB),  64'hF);
    check({tag, ".dstE"},  64'(e_dstE),  64'hF);
    check({tag, ".dstM"},  64'(e_dstM),  64'hF);
    check({tag, ".valA"},  e_valA,       64'h0);
  endtask

  initial begin
    logic [63:0] exp_byp;
    idle_inputs();
    rst = 1'b1;
    #2;
    tick();
    rst = 1'b0;
    check_bubble("reset");

    // Fresh regfile reads zero
    feed(4'h6, 4'h0, 4'h1, 64'h0, 64'h0);
    tick();
    check("rst_rd.valA", e_valA, 64'h0);
    check("rst_rd.valB", e_valB, 64'h0);
    check("rst_rd.valid", 64'(e_valid), 64'h1);

    // E write of r2, then rrmovq r2->r3
    idle_inputs(); wE_dst = 4'h2; wE_val = 64'h55;
    tick();
    idle_inputs(); feed(4'h2, 4'h2, 4'h3, 64'h0, 64'h0);
    tick();
    check("rrmov.valA", e_valA, 64'h55);
    check("rrmov.srcA", 64'(e_srcA), 64'h2);
    check("rrmov.srcB", 64'(e_srcB), 64'hF);
    check("rrmov.dstE", 64'(e_dstE), 64'h3);
    check("rrmov.dstM", 64'(e_dstM), 64'hF);

    // call with %rsp = 0x100
    idle_inputs(); wE_dst = 4'h4; wE_val = 64'h100;
    tick();
    idle_inputs(); feed(4'h8, 4'hF, 4'hF, 64'h2000, 64'h1A);
    tick();
    check("call.valA", e_valA, 64'h1A);
    check("call.valB", e_valB, 64'h100);
    check("call.valC", e_valC, 64'h2000);
    check("call.dstE", 64'(e_dstE), 64'h4);
    check("call.srcA", 64'(e_srcA), 64'hF);
    check("call.srcB", 64'(e_srcB), 64'h4);

    // Stall holds while new inputs arrive; write-back still lands in r5
    idle_inputs(); stall = 1'b1; feed(4'h6, 4'h2, 4'h3, 64'h0, 64'h0);
    wE_dst = 4'h5; wE_val = 64'h99;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall.icode", 64'(e_icode), 64'h8);
      check("stall.valA", e_valA, 64'h1A);
      check("stall.valid", 64'(e_valid), 64'h1);
    end
    bubble = 1'b1;
    tick();
    check_bubble("stall_bubble");

    // Shared E/M destination: M wins
    idle_inputs(); wE_dst = 4'h4; wE_val = 64'h1; wM_dst = 4'h4; wM_val = 64'h2;
    tick();
    idle_inputs(); feed(4'hB, 4'h7, 4'hF, 64'h0, 64'h0);
    tick();
    check("popq.valA", e_valA, 64'h2);
    check("popq.valB", e_valB, 64'h2);
    check("popq.dstE", 64'(e_dstE), 64'h4);
    check("popq.dstM", 64'(e_dstM), 64'h7);
    idle_inputs(); feed(4'h5, 4'h1, 4'h5, 64'h8, 64'h0);
    tick();
    check("mrmov.valB", e_valB, 64'h99);
    check("mrmov.dstM", 64'(e_dstM), 64'h1);
    check("mrmov.dstE", 64'(e_dstE), 64'hF);

    // Same-cycle write of r6 while OPq reads it
    idle_inputs(); wE_dst = 4'h6; wE_val = 64'h11;
    tick();
    idle_inputs(); feed(4'h6, 4'h6, 4'h2, 64'h0, 64'h0); wE_dst = 4'h6; wE_val = 64'h77;
`ifdef DECODE_WB_BYPASS_EN
    exp_byp = 64'h77;
`else
    exp_byp = 64'h11;
`endif
    tick();
    check("same_cyc.valA", e_valA, exp_byp);
    check("same_cyc.valB", e_valB, 64'h55);
    check("same_cyc.dstE", 64'(e_dstE), 64'h2);
    idle_inputs(); feed(4'h6, 4'h6, 4'h2, 64'h0, 64'h0);
    tick();
    check("next_cyc.valA", e_valA, 64'h77);

    // Illegal icode
    idle_inputs(); feed(4'hC, 4'h2, 4'h3, 64'h0, 64'h0);
    tick();
    check("ill.err", 64'(e_ins_err), 64'h1);
    check("ill.valid", 64'(e_valid), 64'h1);
    check("ill.icode", 64'(e_icode), 64'hC);
    check("ill.srcA", 64'(e_srcA), 64'hF);
    check("ill.srcB", 64'(e_srcB), 64'hF);
    check("ill.dstE", 64'(e_dstE), 64'hF);
    check("ill.dstM", 64'(e_dstM), 64'hF);

    // No valid input -> bubble
    idle_inputs();
    tick();
    check_bubble("idle");
    check("idle.err", 64'(e_ins_err), 64'h0);

    // Reset during stall drops held instruction and clears registers
    idle_inputs(); feed(4'h2, 4'h2, 4'h3, 64'h0, 64'h0);
    tick();
    check("pre_rst.valid", 64'(e_valid), 64'h1);
    stall = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    check_bubble("rst_stall");
    idle_inputs(); feed(4'h2, 4'h2, 4'h3, 64'h0, 64'h0);
    tick();
    check("post_rst.valA", e_valA, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
